// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if
//   Start request, operands and result bundle for the bit-serial adder.
//   master: start, A, B, Cin out; busy, done, Sum, Carry in.
//   slave : start, A, B, Cin in; busy, done, Sum, Carry out.
interface serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Sum;
  logic             Carry;

  modport master (
    output start, A, B, Cin,
    input  busy, done, Sum, Carry
  );

  modport slave (
    input  start, A, B, Cin,
    output busy, done, Sum, Carry
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// full_adder
//   One-bit full adder cell.
//   a, b, cin : inputs
//   sum, carry: outputs
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// serial_adder_ctrl
//   Bit-serial adder: latches A, B, Cin on an accepted start, feeds one bit
//   pair per clock (LSB first) through a single full_adder with the carry
//   held in a flop, then presents {Carry, Sum} = A + B + Cin with a one-cycle
//   done pulse. WIDTH+2 cycles per add.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of serial_adder_ctrl_if
//         (start/A/B/Cin in, busy/done/Sum/Carry out)
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  // Holds the WIDTH-1 sum bits already produced; the final bit comes
  // straight from the cell on the completing edge.
  logic [WIDTH-2:0] r_res_sr;
  logic [CW-1:0]    r_cnt;
  logic             r_carry_ff;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  logic             w_fa_sum;
  logic             w_fa_carry;
  logic [WIDTH-1:0] w_res_cat;
  logic             w_accept;
  logic             w_last;

  full_adder u_fa (
    .a     (r_a_sr[0]),
    .b     (r_b_sr[0]),
    .cin   (r_carry_ff),
    .sum   (w_fa_sum),
    .carry (w_fa_carry)
  );

  assign w_res_cat = {w_fa_sum, r_res_sr};
  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_last    = (r_state == S_ADD) && (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_ADD;
      S_ADD:   if (w_last)    w_next = S_DONE;
      S_DONE:                 w_next = S_IDLE;
      default:                w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res_sr   <= '0;
      r_cnt      <= '0;
      r_carry_ff <= 1'b0;
      r_sum      <= '0;
      r_carry    <= 1'b0;
    end else if (w_accept) begin
      r_a_sr     <= bus.A;
      r_b_sr     <= bus.B;
      r_carry_ff <= bus.Cin;
      r_cnt      <= '0;
    end else if (r_state == S_ADD) begin
      r_a_sr     <= r_a_sr >> 1;
      r_b_sr     <= r_b_sr >> 1;
      r_carry_ff <= w_fa_carry;
      r_res_sr   <= w_res_cat[WIDTH-1:1];
      r_cnt      <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum   <= w_res_cat;
        r_carry <= w_fa_carry;
      end
    end
  end

  assign bus.busy  = (r_state == S_ADD);
  assign bus.done  = (r_state == S_DONE);
  assign bus.Sum   = r_sum;
  assign bus.Carry = r_carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Directed and random stimulus for serial_adder_ctrl (WIDTH=8). A timing
//   model driven only by the bench's own inputs predicts busy/done/Sum/Carry
//   every cycle; directed cases add hand-computed literal expectations.
module tb_serial_adder_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: age counts edges since the accepting edge
  // (-1 when idle). busy for ages 0..WIDTH-1, done at age WIDTH,
  // result published on the edge that reaches age WIDTH.
  int             m_age   = -1;
  logic [WIDTH:0] m_pend  = '0;
  logic [WIDTH-1:0] m_sum = '0;
  logic           m_carry = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age   <= -1;
      m_pend  <= '0;
      m_sum   <= '0;
      m_carry <= 1'b0;
    end else if (m_age < 0) begin
      if (bus.start) begin
        m_age  <= 0;
        m_pend <= {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin};
      end
    end else if (m_age == WIDTH) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
      if (m_age == WIDTH - 1) {m_carry, m_sum} <= m_pend;
    end
  end

  always @(negedge clk) begin
    check("busy",  32'(bus.busy),  32'((m_age >= 0) && (m_age < WIDTH)));
    check("done",  32'(bus.done),  32'(m_age == WIDTH));
    check("Sum",   32'(bus.Sum),   32'(m_sum));
    check("Carry", 32'(bus.Carry), 32'(m_carry));
  end

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    bus.Cin   = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int i = 1; i <= 4 * WIDTH; i++) begin
      @(negedge clk);
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done, want done within %0d cycles", 4 * WIDTH);
    end
  endtask

  task automatic run_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                         input logic [WIDTH-1:0] es, input logic ec, input string tag);
    int cyc;
    start_op(a, b, c);
    wait_done(cyc);
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH + 1));
    check({tag, "_sum"},     32'(bus.Sum),   32'(es));
    check({tag, "_carry"},   32'(bus.Carry), 32'(ec));
    @(negedge clk);
    check({tag, "_done_len"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, want finish before 500000");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int np;
    int last;
    logic [WIDTH-1:0] ra, rb, es;
    logic             rc, ec;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.Cin   = 1'b0;

    #1 rst = 1'b1;
    #2;
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.Sum),   32'd0);
    check("rst_carry", 32'(bus.Carry), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // zero operands, busy must rise right after accept
    start_op(8'h00, 8'h00, 1'b0);
    check("zero_busy", 32'(bus.busy), 32'd1);
    wait_done(cyc);
    check("zero_latency", 32'(cyc), 32'(WIDTH + 1));
    check("zero_sum",     32'(bus.Sum),   32'h00);
    check("zero_carry",   32'(bus.Carry), 32'd0);
    @(negedge clk);

    run_add(8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, "plain");
    run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap_b");
    run_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "wrap_cin");
    run_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, "wrap_all");

    // start during ADD is ignored; operand changes after accept have no effect
    start_op(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 8'hFF;
    bus.B     = 8'hFF;
    bus.Cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 8'h55;
    bus.B     = 8'hAA;
    check("ign_hold_sum",   32'(bus.Sum),   32'h00);
    check("ign_hold_carry", 32'(bus.Carry), 32'd1);
    wait_done(cyc);
    check("ign_sum",   32'(bus.Sum),   32'h30);
    check("ign_carry", 32'(bus.Carry), 32'd0);
    @(negedge clk);
    check("ign_done_len", 32'(bus.done), 32'd0);

    // asynchronous reset mid-add, between clock edges
    start_op(8'h12, 8'h34, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy",  32'(bus.busy),  32'd0);
    check("arst_done",  32'(bus.done),  32'd0);
    check("arst_sum",   32'(bus.Sum),   32'd0);
    check("arst_carry", 32'(bus.Carry), 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    np = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      @(negedge clk);
      if (bus.done) np++;
    end
    check("arst_no_done", 32'(np), 32'd0);
    run_add(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, "post_rst");

    // start held high: back-to-back adds every WIDTH+2 cycles
    @(negedge clk);
    #1;
    bus.start = 1'b1;
    bus.A     = 8'h80;
    bus.B     = 8'h80;
    bus.Cin   = 1'b0;
    np   = 0;
    last = -1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (bus.done) begin
        np++;
        check("held_sum",   32'(bus.Sum),   32'h00);
        check("held_carry", 32'(bus.Carry), 32'd1);
        if (last >= 0) check("held_period", 32'(i - last), 32'(WIDTH + 2));
        last = i;
      end
    end
    check("held_count", 32'(np), 32'd4);
    #1 bus.start = 1'b0;
    wait_done(cyc);
    @(negedge clk);

    // random operand sets against plain arithmetic
    for (int n = 0; n < 200; n++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rc = 1'($urandom);
      {ec, es} = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_add(ra, rb, rc, es, ec, "rand");
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial add controller built around one full_adder cell (A, B, Cin -> Sum, Carry).
- Latches two WIDTH-bit operands and a carry-in on a start request.
- Feeds the cell one bit pair per clock, LSB first, with the carry held in a flip-flop.
- Collects the serial sum and reports WIDTH-bit Sum plus carry-out with a done pulse. Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin an add; sampled only in IDLE.
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- Cin  input  1  carry-in; sampled on the accepting edge.
- busy  output  1  high while bits are being processed (ADD state).
- done  output  1  one-cycle pulse: Sum/Carry hold a fresh result.
- Sum  output  WIDTH  registered result, A+B+Cin mod 2^WIDTH.
- Carry  output  1  registered carry-out of the MSB.

Behaviour:
- Interface: one clock domain (clk). Asynchronous, active-high reset rst.
- rst asserted, at any time including mid-operation: state=IDLE immediately. busy=0, done=0, Sum=0, Carry=0. Shift registers, bit counter and carry flip-flop cleared. The in-flight add is discarded.
- States: IDLE, ADD, DONE.
- IDLE: start=1 at edge k -> latch A, B into shift registers and Cin into carry_ff; bit counter=0; next state ADD. start=0 -> stay in IDLE.
- ADD: at each edge, drive the cell with a=A_sr[0], b=B_sr[0], cin=carry_ff.
  - carry_ff <= cell Carry.
  - The cell Sum bit shifts into the MSB of the result shift register.
  - A_sr and B_sr shift right by one. Counter increments.
- ADD exit: at the edge where counter==WIDTH-1, i.e. edge k+WIDTH:
  - Sum <= completed result, with the final bit included.
  - Carry <= final cell Carry.
  - Next state DONE.
- DONE: done=1 for exactly one cycle. Next edge -> IDLE unconditionally.
- Latency: start accepted at edge k -> busy high from k to k+WIDTH. Sum/Carry update at edge k+WIDTH. done high from k+WIDTH to k+WIDTH+1. Next start can be accepted at edge k+WIDTH+2; throughput is WIDTH+2 cycles per add.
- start is ignored in ADD and DONE. There is no queuing; a held-high start is accepted again once back in IDLE.
- Changes on A, B or Cin after the accepting edge have no effect on the running add.
- Sum/Carry change only at completion. They hold their value through IDLE and through the next add until that add completes.
- busy and done are never high together. Both are registered, decoded from state flops only.
- Arithmetic: {Carry, Sum} == A + B + Cin, computed to WIDTH+1 bits. The all-ones wrap gives Sum=0, Carry=1.

Test Plan:
- WIDTH=8, reset then A=0x00, B=0x00, Cin=0, one-cycle start -> busy high for 8 cycles, then done pulse for 1 cycle; Sum=0x00, Carry=0.
- A=0x3C, B=0x42, Cin=0 -> Sum=0x7E, Carry=0. done is exactly 1 cycle, 9 edges after the accepting edge.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Carry=1. Then A=0xFF, B=0x00, Cin=1 -> Sum=0x00, Carry=1. Then A=0xA5, B=0x5A, Cin=1 -> Sum=0x00, Carry=1.
- Start add A=0x10, B=0x20, Cin=0. Pulse start with A=0xFF, B=0xFF at cycle 3 of ADD, and change A/B mid-add -> second start ignored. Result is Sum=0x30, Carry=0. Previous Sum stays stable until completion.
- Assert rst asynchronously at cycle 4 of ADD, mid-clock -> busy, done, Sum and Carry go to 0 without a clock edge. No done pulse follows. A fresh add A=0x01, B=0x01, Cin=1 after reset gives Sum=0x03, Carry=0.
- Hold start high continuously with A=0x80, B=0x80, Cin=0 -> back-to-back adds, one every 10 cycles. Each result is Sum=0x00, Carry=1.
- Self-check: every done pulse is compared against a reference A+B+Cin over 200 random operand sets.
